me_best_mv_tracker: RTL and testbench

//  Parametrised successor stage to the basic-layer SAD search engine. It consumes one

---
 rtl/me_best_mv_tracker.sv | 168 ++++++++++++++++
 tb/tb_me_best_mv_tracker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/me_best_mv_tracker.sv
// Tracks the per-partition minimum rate-weighted SAD cost and its motion vector
// over a raster-ordered SEARCH_W x SEARCH_H candidate window.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; results of the last window held
// RUN     | accepting one candidate per sad_valid cycle
// DONE    | one-cycle pulse after the last candidate; results final
module me_best_mv_tracker #(
  parameter int NUM_PART = 4,
  parameter int SAD_W    = 16,
  parameter int SEARCH_W = 32,
  parameter int SEARCH_H = 64,
  parameter int LAMBDA   = 4,
  parameter int COST_EN  = 1,
  localparam int CW      = $clog2(SEARCH_W),
  localparam int RW      = $clog2(SEARCH_H),
  localparam int COST_W  = SAD_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sad_valid,
  input  logic [NUM_PART*SAD_W-1:0]  sad_in,
  output logic                       busy,
  output logic                       done,
  output logic [CW-1:0]              search_column_count,
  output logic [RW-1:0]              search_row_count,
  output logic [NUM_PART*COST_W-1:0] best_cost,
  output logic [NUM_PART*CW-1:0]     best_mvx,
  output logic [NUM_PART*RW-1:0]     best_mvy
);

  localparam int XW     = 64;
  localparam int HALF_W = SEARCH_W / 2;
  localparam int HALF_H = SEARCH_H / 2;
  localparam logic [COST_W-1:0] COST_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [COST_W-1:0] cost_q [NUM_PART];
  logic [COST_W-1:0] cost_d [NUM_PART];
  logic [CW-1:0]     mvx_q  [NUM_PART];
  logic [CW-1:0]     mvx_d  [NUM_PART];
  logic [RW-1:0]     mvy_q  [NUM_PART];
  logic [RW-1:0]     mvy_d  [NUM_PART];
  logic [XW-1:0]     raw_cost  [NUM_PART];
  logic [COST_W-1:0] cand_cost [NUM_PART];

  logic          accept, last_col, last_row, last_cand;
  logic [XW-1:0] abs_x, abs_y, mv_cost;
  logic [CW-1:0] cur_mvx;
  logic [RW-1:0] cur_mvy;

  assign last_col  = (col_q == CW'(SEARCH_W - 1));
  assign last_row  = (row_q == RW'(SEARCH_H - 1));
  assign last_cand = last_col && last_row;
  assign accept    = (state_q == ST_RUN) && sad_valid && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // start overrides every transition, including the last-candidate one
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN:  if (sad_valid && last_cand) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // MV of the current candidate, centred on the window middle
  always_comb begin
    abs_x   = (XW'(col_q) >= XW'(HALF_W)) ? XW'(col_q) - XW'(HALF_W) : XW'(HALF_W) - XW'(col_q);
    abs_y   = (XW'(row_q) >= XW'(HALF_H)) ? XW'(row_q) - XW'(HALF_H) : XW'(HALF_H) - XW'(row_q);
    mv_cost = (COST_EN != 0) ? XW'(LAMBDA) * (abs_x + abs_y) : '0;
    cur_mvx = col_q - CW'(HALF_W);
    cur_mvy = row_q - RW'(HALF_H);
  end

  always_comb begin
    for (int p = 0; p < NUM_PART; p++) begin
      raw_cost[p]  = XW'(sad_in[p*SAD_W +: SAD_W]) + mv_cost;
      cand_cost[p] = (raw_cost[p] > XW'(COST_MAX)) ? COST_MAX : raw_cost[p][COST_W-1:0];
    end
  end

  // strict compare so the earliest raster candidate keeps a tie
  always_comb begin
    for (int p = 0; p < NUM_PART; p++) begin
      cost_d[p] = cost_q[p];
      mvx_d[p]  = mvx_q[p];
      mvy_d[p]  = mvy_q[p];
      if (start) begin
        cost_d[p] = COST_MAX;
        mvx_d[p]  = '0;
        mvy_d[p]  = '0;
      end else if (accept && (cand_cost[p] < cost_q[p])) begin
        cost_d[p] = cand_cost[p];
        mvx_d[p]  = cur_mvx;
        mvy_d[p]  = cur_mvy;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      for (int p = 0; p < NUM_PART; p++) begin
        cost_q[p] <= COST_MAX;
        mvx_q[p]  <= '0;
        mvy_q[p]  <= '0;
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      for (int p = 0; p < NUM_PART; p++) begin
        cost_q[p] <= cost_d[p];
        mvx_q[p]  <= mvx_d[p];
        mvy_q[p]  <= mvy_d[p];
      end
    end
  end

  always_comb begin
    search_column_count = col_q;
    search_row_count    = row_q;
    for (int p = 0; p < NUM_PART; p++) begin
      best_cost[p*COST_W +: COST_W] = cost_q[p];
      best_mvx[p*CW +: CW]          = mvx_q[p];
      best_mvy[p*RW +: RW]          = mvy_q[p];
    end
  end

endmodule

// File: tb/tb_me_best_mv_tracker.sv
// Directed bench for me_best_mv_tracker: four parameterisations share clk/rst,
// sel routes start/sad_valid to the instance under test.
module tb_me_best_mv_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sad_valid;
  int   sel, cur_w, tb_col, tb_row;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [3:0] start_v, valid_v, busy_v, done_v;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      start_v[k] = start && (sel == k);
      valid_v[k] = sad_valid && (sel == k);
    end
  end

  // u_def: defaults with COST_EN=0
  logic [63:0] sad_0;
  logic [4:0]  col_0;
  logic [5:0]  row_0;
  logic [67:0] cost_0;
  logic [19:0] mvx_0;
  logic [23:0] mvy_0;
  assign sad_0 = {4{16'h0100}};

  // u_cost: default window, LAMBDA=4
  logic [15:0] sad_1;
  logic [4:0]  col_1;
  logic [5:0]  row_1;
  logic [16:0] cost_1;
  logic [4:0]  mvx_1;
  logic [5:0]  mvy_1;

  // u_small: 4x4, two partitions, COST_EN=0
  logic [31:0] sad_2;
  logic [1:0]  col_2, row_2;
  logic [33:0] cost_2;
  logic [3:0]  mvx_2, mvy_2;

  // u_sat: 4x4, huge LAMBDA so every off-centre cost overflows COST_W
  logic [15:0] sad_3;
  logic [1:0]  col_3, row_3;
  logic [16:0] cost_3;
  logic [1:0]  mvx_3, mvy_3;
  assign sad_3 = 16'hFFFF;

  always_comb begin
    sad_1 = 16'hFFFF;
    if (tb_col == 0 && tb_row == 0)        sad_1 = 16'd0;
    else if (tb_col == 16 && tb_row == 32) sad_1 = 16'd40;
    sad_2 = {((tb_col == 3 && tb_row == 3) ? 16'd50 : 16'd200),
             ((tb_col == 2 && tb_row == 1) ? 16'd7  : 16'd100)};
  end

  me_best_mv_tracker #(.NUM_PART(4), .SAD_W(16), .SEARCH_W(32), .SEARCH_H(64),
                       .LAMBDA(4), .COST_EN(0)) u_def (
    .clk(clk), .rst(rst), .start(start_v[0]), .sad_valid(valid_v[0]), .sad_in(sad_0),
    .busy(busy_v[0]), .done(done_v[0]), .search_column_count(col_0),
    .search_row_count(row_0), .best_cost(cost_0), .best_mvx(mvx_0), .best_mvy(mvy_0));

  me_best_mv_tracker #(.NUM_PART(1), .SAD_W(16), .SEARCH_W(32), .SEARCH_H(64),
                       .LAMBDA(4), .COST_EN(1)) u_cost (
    .clk(clk), .rst(rst), .start(start_v[1]), .sad_valid(valid_v[1]), .sad_in(sad_1),
    .busy(busy_v[1]), .done(done_v[1]), .search_column_count(col_1),
    .search_row_count(row_1), .best_cost(cost_1), .best_mvx(mvx_1), .best_mvy(mvy_1));

  me_best_mv_tracker #(.NUM_PART(2), .SAD_W(16), .SEARCH_W(4), .SEARCH_H(4),
                       .LAMBDA(4), .COST_EN(0)) u_small (
    .clk(clk), .rst(rst), .start(start_v[2]), .sad_valid(valid_v[2]), .sad_in(sad_2),
    .busy(busy_v[2]), .done(done_v[2]), .search_column_count(col_2),
    .search_row_count(row_2), .best_cost(cost_2), .best_mvx(mvx_2), .best_mvy(mvy_2));

  me_best_mv_tracker #(.NUM_PART(1), .SAD_W(16), .SEARCH_W(4), .SEARCH_H(4),
                       .LAMBDA(70000), .COST_EN(1)) u_sat (
    .clk(clk), .rst(rst), .start(start_v[3]), .sad_valid(valid_v[3]), .sad_in(sad_3),
    .busy(busy_v[3]), .done(done_v[3]), .search_column_count(col_3),
    .search_row_count(row_3), .best_cost(cost_3), .best_mvx(mvx_3), .best_mvy(mvy_3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    sad_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic accept(input int idx);
    tb_col = idx % cur_w;
    tb_row = idx / cur_w;
    sad_valid = 1'b1;
    tick();
    sad_valid = 1'b0;
  endtask

  // drives candidates first..w*h-1, optionally with random idle gaps
  task automatic run_window(input int w, input int h, input int first, input bit gaps);
    int early = 0;
    cur_w = w;
    for (int i = first; i < w * h; i++) begin
      if (gaps) begin
        int ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          tick();
          if (done_v[sel]) early++;
        end
      end
      accept(i);
      if (i < w * h - 1 && done_v[sel]) early++;
    end
    chk("no_early_done", 64'(early), 64'd0);
    chk("done_after_last", 64'(done_v[sel]), 64'd1);
    chk("busy_in_done", 64'(busy_v[sel]), 64'd0);
    tick();
    chk("done_one_cycle", 64'(done_v[sel]), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sad_valid = 1'b0;
    sel = 0; cur_w = 32; tb_col = 0; tb_row = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_best_cost", 64'(cost_0[16:0]), 64'h1FFFF);

    // reset in the middle of a window
    sel = 0;
    do_start();
    chk("start_busy", 64'(busy_v[0]), 64'd1);
    cur_w = 32;
    for (int i = 0; i < 5; i++) accept(i);
    chk("mid_col", 64'(col_0), 64'd5);
    chk("mid_best", 64'(cost_0[16:0]), 64'h100);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", 64'(busy_v[0]), 64'd0);
    chk("rstmid_done", 64'(done_v[0]), 64'd0);
    chk("rstmid_col", 64'(col_0), 64'd0);
    chk("rstmid_row", 64'(row_0), 64'd0);
    chk("rstmid_cost_p0", 64'(cost_0[16:0]), 64'h1FFFF);
    chk("rstmid_cost_p3", 64'(cost_0[67:51]), 64'h1FFFF);
    chk("rstmid_mvx", 64'(mvx_0), 64'd0);
    #1 rst = 1'b0;
    tick();

    // constant SAD: first candidate wins every tie
    do_start();
    run_window(32, 64, 0, 1'b0);
    chk("def_cost_p0", 64'(cost_0[16:0]), 64'h100);
    chk("def_cost_p3", 64'(cost_0[67:51]), 64'h100);
    chk("def_mvx_p0", 64'(mvx_0[4:0]), 64'h10);
    chk("def_mvy_p0", 64'(mvy_0[5:0]), 64'h20);
    chk("def_mvx_p3", 64'(mvx_0[19:15]), 64'h10);
    chk("def_col_wrap", 64'(col_0), 64'd0);
    chk("def_row_wrap", 64'(row_0), 64'd0);
    sad_valid = 1'b1;
    tick();
    tick();
    sad_valid = 1'b0;
    chk("idle_valid_col", 64'(col_0), 64'd0);
    chk("idle_valid_busy", 64'(busy_v[0]), 64'd0);

    // MV cost: centre beats the zero-SAD corner
    sel = 1;
    do_start();
    cur_w = 32;
    accept(0);
    chk("cost_corner", 64'(cost_1), 64'd192);
    chk("cost_corner_mvx", 64'(mvx_1), 64'h10);
    chk("cost_corner_mvy", 64'(mvy_1), 64'h20);
    run_window(32, 64, 1, 1'b0);
    chk("cost_centre", 64'(cost_1), 64'd40);
    chk("cost_centre_mvx", 64'(mvx_1), 64'd0);
    chk("cost_centre_mvy", 64'(mvy_1), 64'd0);

    // small window, two partitions
    sel = 2;
    do_start();
    run_window(4, 4, 0, 1'b0);
    chk("small_cost_p0", 64'(cost_2[16:0]), 64'd7);
    chk("small_mvx_p0", 64'(mvx_2[1:0]), 64'd0);
    chk("small_mvy_p0", 64'(mvy_2[1:0]), 64'h3);
    chk("small_cost_p1", 64'(cost_2[33:17]), 64'd50);
    chk("small_mvx_p1", 64'(mvx_2[3:2]), 64'd1);
    chk("small_mvy_p1", 64'(mvy_2[3:2]), 64'd1);
    tick();
    tick();
    chk("small_hold_cost", 64'(cost_2[16:0]), 64'd7);

    do_start();
    run_window(4, 4, 0, 1'b1);
    chk("gap_cost_p0", 64'(cost_2[16:0]), 64'd7);
    chk("gap_mvy_p0", 64'(mvy_2[1:0]), 64'h3);
    chk("gap_cost_p1", 64'(cost_2[33:17]), 64'd50);
    chk("gap_mvx_p1", 64'(mvx_2[3:2]), 64'd1);

    // restart at candidate 10
    do_start();
    cur_w = 4;
    for (int i = 0; i < 10; i++) accept(i);
    tb_col = 2; tb_row = 2;
    start = 1'b1; sad_valid = 1'b1;
    tick();
    start = 1'b0; sad_valid = 1'b0;
    chk("restart_col", 64'(col_2), 64'd0);
    chk("restart_row", 64'(row_2), 64'd0);
    chk("restart_busy", 64'(busy_v[2]), 64'd1);
    chk("restart_cost", 64'(cost_2[16:0]), 64'h1FFFF);
    run_window(4, 4, 0, 1'b0);
    chk("restart_final", 64'(cost_2[16:0]), 64'd7);

    // start together with the last candidate
    do_start();
    cur_w = 4;
    for (int i = 0; i < 15; i++) accept(i);
    tb_col = 3; tb_row = 3;
    start = 1'b1; sad_valid = 1'b1;
    tick();
    start = 1'b0; sad_valid = 1'b0;
    chk("startlast_done", 64'(done_v[2]), 64'd0);
    chk("startlast_busy", 64'(busy_v[2]), 64'd1);
    chk("startlast_col", 64'(col_2), 64'd0);
    chk("startlast_cost_p1", 64'(cost_2[33:17]), 64'h1FFFF);
    tick();
    chk("startlast_nodone", 64'(done_v[2]), 64'd0);

    // saturation: off-centre costs clamp and never beat the all-ones reset value
    sel = 3;
    do_start();
    cur_w = 4;
    for (int i = 0; i < 4; i++) accept(i);
    chk("sat_cost_row0", 64'(cost_3), 64'h1FFFF);
    chk("sat_mvx_row0", 64'(mvx_3), 64'd0);
    chk("sat_mvy_row0", 64'(mvy_3), 64'd0);
    run_window(4, 4, 4, 1'b0);
    chk("sat_final_cost", 64'(cost_3), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
